// File: rtl/wb_simcard_v2.sv
// wb_simcard_v2: Wishbone register front-end for a SIM card core.
// Holds CTRL/STATUS/TIMEOUT, synchronises the core's done level, snapshots
// the core result into DATA registers and runs an IDLE/BUSY sequencer with
// a watchdog counter.
module wb_simcard_v2 #(
  parameter int NWORDS    = 5,
  parameter int DW_BITS   = 2,
  parameter int TMO_RESET = 50000000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wb_stb_i,
  input  logic                  wb_cyc_i,
  input  logic                  wb_we_i,
  input  logic [31:0]           wb_adr_i,
  input  logic [3:0]            wb_sel_i,
  input  logic [31:0]           wb_dat_i,
  output logic [31:0]           wb_dat_o,
  output logic                  wb_ack_o,
  output logic                  sc_en,
  output logic [DW_BITS-1:0]    sc_dw,
  input  logic                  sc_done,
  input  logic [32*NWORDS-1:0]  sc_data,
  output logic                  irq
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  localparam logic [5:0] IDX_CTRL   = 6'd0;
  localparam logic [5:0] IDX_STATUS = 6'd1;
  localparam logic [5:0] IDX_TMO    = 6'd2;
  localparam logic [5:0] IDX_RSVD   = 6'd3;
  localparam int         IDX_DATA0  = 4;

  // Architectural state
  state_t               state_q;
  logic                 en_q;
  logic                 irq_en_q;
  logic [DW_BITS-1:0]   dw_q;
  logic                 st_done_q;
  logic                 st_tmo_q;
  logic                 st_ovr_q;
  logic [31:0]          timeout_q;
  logic [31:0]          cnt_q;
  logic [31:0]          data_q [NWORDS];

  // Done synchroniser (two sync flops plus one edge-detect flop)
  logic                 sync1_q;
  logic                 sync2_q;
  logic                 sync3_q;

  // Bus handshake and registered outputs
  logic                 served_q;
  logic                 ack_q;
  logic [31:0]          dat_q;
  logic                 irq_q;

  // Decodes
  logic                 bus_req_s;
  logic                 wr_s;
  logic [5:0]           adr_idx_s;
  logic                 wr_ctrl_s;
  logic                 wr_stat_s;
  logic                 wr_tmo_s;
  logic                 done_evt_s;
  logic                 en_rise_s;
  logic                 en_clr_s;
  logic                 tmo_hit_s;
  logic [31:0]          rd_data_d;
  logic                 unused_s;

  // served_q blocks a second ack until the master drops stb/cyc; it comes out
  // of reset set so a transfer held across reset is never acknowledged.
  assign bus_req_s  = wb_stb_i & wb_cyc_i & ~served_q;
  assign wr_s       = bus_req_s & wb_we_i;
  assign adr_idx_s  = wb_adr_i[7:2];
  assign wr_ctrl_s  = wr_s & (adr_idx_s == IDX_CTRL);
  assign wr_stat_s  = wr_s & (adr_idx_s == IDX_STATUS) & wb_sel_i[0];
  assign wr_tmo_s   = wr_s & (adr_idx_s == IDX_TMO);

  assign done_evt_s = sync2_q & ~sync3_q;
  assign en_rise_s  = wr_ctrl_s & wb_sel_i[0] & wb_dat_i[0] & ~en_q;
  assign en_clr_s   = wr_ctrl_s & wb_sel_i[0] & ~wb_dat_i[0];
  // Watchdog expiry loses to a completion or a software stop in the same cycle.
  assign tmo_hit_s  = (state_q == ST_BUSY) & (cnt_q == 32'd0) & (timeout_q != 32'd0)
                      & ~done_evt_s & ~en_clr_s;

  assign unused_s   = ^{wb_adr_i[31:8], wb_adr_i[1:0]};

  assign wb_ack_o   = ack_q;
  assign wb_dat_o   = dat_q;
  assign sc_en      = en_q;
  assign sc_dw      = dw_q;
  assign irq        = irq_q;

  // Read data multiplexer for the addressed word.
  always_comb begin
    rd_data_d = 32'd0;
    case (adr_idx_s)
      IDX_CTRL: begin
        rd_data_d[0]            = en_q;
        rd_data_d[1]            = irq_en_q;
        rd_data_d[8 +: DW_BITS] = dw_q;
      end
      IDX_STATUS: rd_data_d[3:0] = {st_ovr_q, st_tmo_q, (state_q == ST_BUSY), st_done_q};
      IDX_TMO:    rd_data_d      = timeout_q;
      IDX_RSVD:   rd_data_d      = 32'd0;
      default: begin
        for (int k = 0; k < NWORDS; k++) begin
          rd_data_d = (adr_idx_s == 6'(IDX_DATA0 + k)) ? data_q[k] : rd_data_d;
        end
      end
    endcase
  end

  // Single-cycle registered ack and read data, zero outside the ack cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      served_q <= 1'b1;
      ack_q    <= 1'b0;
      dat_q    <= 32'd0;
    end else begin
      served_q <= (wb_stb_i & wb_cyc_i) ? (served_q | bus_req_s) : 1'b0;
      ack_q    <= bus_req_s;
      dat_q    <= bus_req_s ? rd_data_d : 32'd0;
    end
  end

  // Bring sc_done into the clock domain and keep one delayed copy for edge detect.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
    end else begin
      sync1_q <= sc_done;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  // Sequencer: CTRL/TIMEOUT/STATUS registers, IDLE/BUSY state and watchdog.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      en_q      <= 1'b0;
      irq_en_q  <= 1'b0;
      dw_q      <= '0;
      st_done_q <= 1'b0;
      st_tmo_q  <= 1'b0;
      st_ovr_q  <= 1'b0;
      timeout_q <= 32'(TMO_RESET);
      cnt_q     <= 32'd0;
    end else begin
      if (tmo_hit_s) begin
        en_q <= 1'b0;
      end else if (wr_ctrl_s && wb_sel_i[0]) begin
        en_q <= wb_dat_i[0];
      end
      if (wr_ctrl_s && wb_sel_i[0]) begin
        irq_en_q <= wb_dat_i[1];
      end
      if (wr_ctrl_s && wb_sel_i[1]) begin
        dw_q <= wb_dat_i[8 +: DW_BITS];
      end
      for (int b = 0; b < 4; b++) begin
        if (wr_tmo_s && wb_sel_i[b]) begin
          timeout_q[8*b +: 8] <= wb_dat_i[8*b +: 8];
        end
      end

      // A set event in the same cycle as a clear leaves the bit set.
      st_done_q <= done_evt_s | (st_done_q & ~(wr_stat_s & wb_dat_i[0]));
      st_tmo_q  <= tmo_hit_s  | (st_tmo_q  & ~(wr_stat_s & wb_dat_i[2]));
      st_ovr_q  <= (done_evt_s & st_done_q) | (st_ovr_q & ~(wr_stat_s & wb_dat_i[3]));

      case (state_q)
        ST_IDLE: begin
          if (en_rise_s) begin
            state_q <= ST_BUSY;
            cnt_q   <= timeout_q;
          end
        end
        ST_BUSY: begin
          if (done_evt_s || en_clr_s || tmo_hit_s) begin
            state_q <= ST_IDLE;
          end else if (cnt_q != 32'd0) begin
            cnt_q <= cnt_q - 32'd1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Snapshot every result word on a completion event; DATA0 is the MSB word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NWORDS; k++) begin
        data_q[k] <= 32'd0;
      end
    end else if (done_evt_s) begin
      for (int k = 0; k < NWORDS; k++) begin
        data_q[k] <= sc_data[32*(NWORDS-1-k) +: 32];
      end
    end
  end

  // Level interrupt from the current enable and sticky status bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_en_q & (st_done_q | st_tmo_q);
    end
  end

endmodule
